// File: rtl/mem_burst_reader_if.sv
// Bus bundle for mem_burst_reader: job request/status, memory read port and
// the output stream. master = the reader, slave = memory/core/job source.
interface mem_burst_reader_if;
   logic        start;
   logic [15:0] base_addr;
   logic [15:0] count;
   logic        busy;
   logic        done;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_address;
   logic [15:0] mem_data_in;
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_ready;
   logic        out_last;

   modport master (
      input  start, base_addr, count, mem_data_in, out_ready,
      output busy, done, mem_read, mem_write, mem_address,
             out_valid, out_data, out_last
   );

   modport slave (
      output start, base_addr, count, mem_data_in, out_ready,
      input  busy, done, mem_read, mem_write, mem_address,
             out_valid, out_data, out_last
   );
endinterface

// File: rtl/mem_burst_reader.sv
// mem_burst_reader: fetches count consecutive words starting at base_addr
// and streams them through a FIFO_DEPTH-word buffer to a valid/ready sink.
// Optional feature: define MEM_BURST_READER_LAST_EN to drive out_last on the
// final word of each job; otherwise out_last is tied low.
module mem_burst_reader #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   mem_burst_reader_if.master  bus
);

   localparam int          AW      = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

   state_t      state;
   logic        busy_q;
   logic        done_q;
   logic [15:0] addr_q;
   logic [15:0] remaining;

   logic [FIFO_DEPTH-1:0][15:0] fifo_mem;
   logic [AW-1:0]               wr_ptr;
   logic [AW-1:0]               rd_ptr;
   logic [AW:0]                 fifo_cnt;
   logic                        fifo_full;
   logic                        push;
   logic                        pop;
   logic                        rd_en;

   // Fullness is judged on the registered count only, so a pop in the same
   // cycle never frees a slot for a push.
   assign fifo_full = (fifo_cnt == DEPTH_C);
   assign rd_en     = (state == FETCH) && (remaining != 16'd0) && !fifo_full;
   assign push      = rd_en;
   assign pop       = bus.out_valid && bus.out_ready;

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.mem_read    = rd_en;
   assign bus.mem_write   = 1'b0;
   assign bus.mem_address = addr_q;
   assign bus.out_valid   = (fifo_cnt != '0);
   assign bus.out_data    = fifo_mem[rd_ptr];

   // Stream buffer: memory data is captured on the edge that ends a read cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_mem <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= bus.mem_data_in;
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // Job sequencer: IDLE -> FETCH -> DRAIN -> DONE, with busy/done registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         addr_q    <= '0;
         remaining <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  addr_q    <= bus.base_addr;
                  remaining <= bus.count;
                  if (bus.count == 16'd0) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end else begin
                     state  <= FETCH;
                     busy_q <= 1'b1;
                  end
               end
            end
            FETCH: begin
               if (push) begin
                  addr_q    <= addr_q + 16'd1;   // wraps FFFF -> 0000
                  remaining <= remaining - 16'd1;
                  if (remaining == 16'd1)
                     state <= DRAIN;
               end
            end
            DRAIN: begin
               // Finish on the edge that pops the final buffered word.
               if ((fifo_cnt == '0) || (pop && fifo_cnt == (AW+1)'(1))) begin
                  state  <= DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef MEM_BURST_READER_LAST_EN
   logic [15:0] pop_left;

   // Words still to be handed to the core; the head is last when one remains.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pop_left <= '0;
      else if (state == IDLE && bus.start)
         pop_left <= bus.count;
      else if (pop)
         pop_left <= pop_left - 16'd1;
   end

   assign bus.out_last = bus.out_valid && (pop_left == 16'd1);
`else
   assign bus.out_last = 1'b0;
`endif

endmodule

// File: tb/tb_mem_burst_reader.sv
// Directed bench for mem_burst_reader: a table of jobs with hand-computed
// streams and timing, plus hand-written reset and abort sequences.
module tb_mem_burst_reader;

   logic clk;
   logic rst_n;

   mem_burst_reader_if bus();

   mem_burst_reader #(.FIFO_DEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   logic [15:0] mem [0:65535];
   assign bus.mem_data_in = mem[bus.mem_address];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] base;
      int          cnt;
      int          stall;     // out_ready low for cycles 1..stall
      int          restart;   // cycle of a stray start pulse (0 = none)
      int          done_cyc;
      int          chk_cyc;
      logic [15:0] chk_addr;
      logic        chk_rd;
      logic [15:0] exp [16];
   } vec_t;

   vec_t vt [7];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic set_vec(input int k, input logic [15:0] base, input int cnt,
                          input int stall, input int restart, input int done_cyc,
                          input int chk_cyc, input logic [15:0] chk_addr,
                          input logic chk_rd, input int w[$]);
      vt[k].base     = base;
      vt[k].cnt      = cnt;
      vt[k].stall    = stall;
      vt[k].restart  = restart;
      vt[k].done_cyc = done_cyc;
      vt[k].chk_cyc  = chk_cyc;
      vt[k].chk_addr = chk_addr;
      vt[k].chk_rd   = chk_rd;
      for (int i = 0; i < 16; i++)
         vt[k].exp[i] = (i < w.size()) ? 16'(w[i]) : 16'd0;
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge after done.
   task automatic run_job(input int k);
      int          nrd, npop, ndone, c;
      logic        fin;
      logic [15:0] ea;
      int          exp_last;
      nrd = 0; npop = 0; ndone = 0; fin = 1'b0; c = 0;
      bus.base_addr = vt[k].base;
      bus.count     = 16'(vt[k].cnt);
      bus.start     = 1'b1;
      bus.out_ready = (vt[k].stall == 0);
      @(posedge clk);
      for (int cyc = 1; cyc <= 80 && !fin; cyc++) begin
         @(negedge clk);
         c = cyc;
         bus.start = (cyc == vt[k].restart);
         if (cyc == vt[k].restart) begin
            bus.base_addr = 16'd998;
            bus.count     = 16'd2;
         end
         bus.out_ready = (cyc > vt[k].stall);
         if (cyc == 1)
            chk($sformatf("job%0d busy_c1", k), int'(bus.busy), int'(vt[k].cnt != 0));
         if (cyc == vt[k].chk_cyc) begin
            chk($sformatf("job%0d addr_c%0d", k, cyc), int'(bus.mem_address), int'(vt[k].chk_addr));
            chk($sformatf("job%0d rd_c%0d", k, cyc), int'(bus.mem_read), int'(vt[k].chk_rd));
         end
         if (bus.mem_read) begin
            ea = vt[k].base + 16'(nrd);
            chk($sformatf("job%0d rd_addr%0d", k, nrd), int'(bus.mem_address), int'(ea));
            nrd++;
         end
         if (bus.out_valid && bus.out_ready) begin
            if (npop < 16)
               chk($sformatf("job%0d word%0d", k, npop), int'(bus.out_data), int'(vt[k].exp[npop]));
`ifdef MEM_BURST_READER_LAST_EN
            exp_last = int'(npop == vt[k].cnt - 1);
`else
            exp_last = 0;
`endif
            chk($sformatf("job%0d last%0d", k, npop), int'(bus.out_last), exp_last);
            npop++;
         end
         if (bus.done) begin
            ndone++;
            fin = 1'b1;
            chk($sformatf("job%0d done_cyc", k), c, vt[k].done_cyc);
            chk($sformatf("job%0d busy_at_done", k), int'(bus.busy), 0);
         end
      end
      bus.start = 1'b0;
      chk($sformatf("job%0d done_seen", k), ndone, 1);
      chk($sformatf("job%0d words", k), npop, vt[k].cnt);
      chk($sformatf("job%0d reads", k), nrd, vt[k].cnt);
      @(negedge clk);
      chk($sformatf("job%0d done_after", k), int'(bus.done), 0);
      chk($sformatf("job%0d busy_after", k), int'(bus.busy), 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " busy"},      int'(bus.busy), 0);
      chk({tag, " done"},      int'(bus.done), 0);
      chk({tag, " mem_read"},  int'(bus.mem_read), 0);
      chk({tag, " mem_write"}, int'(bus.mem_write), 0);
      chk({tag, " mem_addr"},  int'(bus.mem_address), 0);
      chk({tag, " out_valid"}, int'(bus.out_valid), 0);
      chk({tag, " out_data"},  int'(bus.out_data), 0);
      chk({tag, " out_last"},  int'(bus.out_last), 0);
   endtask

   initial begin
      int bad_done;
      for (int i = 0; i < 65536; i++) mem[i] = 16'd0;
      begin
         int a[$] = '{4, 4, 7, 5, 7, 2};
         int b[$] = '{1, 8, 8, 1, 3, 0, 5, 5, 6, 9, 4, 7, 4, 4, 8};
         foreach (a[i]) mem[i] = 16'(a[i]);
         foreach (b[i]) mem[100 + i] = 16'(b[i]);
      end
      mem[16'hFFFE] = 16'd11;
      mem[16'hFFFF] = 16'd12;
      mem[998]      = 16'd9;
      mem[999]      = 16'd3;

      set_vec(0, 16'd0,     6,  0, 0,  8, 1, 16'd0,   1'b1, '{4, 4, 7, 5, 7, 2});
      set_vec(1, 16'd100,  15, 10, 0, 26, 10, 16'd104, 1'b0,
              '{1, 8, 8, 1, 3, 0, 5, 5, 6, 9, 4, 7, 4, 4, 8});
      set_vec(2, 16'd50,    0,  0, 0,  1, 1, 16'd50,  1'b0, '{});
      set_vec(3, 16'hFFFE,  4,  0, 0,  6, 3, 16'd0,   1'b1, '{11, 12, 4, 4});
      set_vec(4, 16'd0,     6,  0, 3,  8, 3, 16'd2,   1'b1, '{4, 4, 7, 5, 7, 2});
      set_vec(5, 16'd998,   2,  0, 0,  4, 2, 16'd999, 1'b1, '{9, 3});
      set_vec(6, 16'd5,     1,  0, 0,  3, 2, 16'd6,   1'b0, '{2});

      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.base_addr = 16'd0;
      bus.count     = 16'd0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk_reset_vals("reset");
      rst_n = 1'b1;
      @(negedge clk);

      for (int k = 0; k < 7; k++)
         run_job(k);

      // Abort mid-FETCH with three words buffered.
      bus.base_addr = 16'd100;
      bus.count     = 16'd15;
      bus.start     = 1'b1;
      bus.out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("abort pre addr",  int'(bus.mem_address), 103);
      chk("abort pre valid", int'(bus.out_valid), 1);
      chk("abort pre busy",  int'(bus.busy), 1);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("abort");
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      bad_done = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus.done || bus.out_valid || bus.busy) bad_done++;
      end
      chk("abort quiet", bad_done, 0);
      run_job(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_burst_reader.md
# mem_burst_reader

Read-side initiator for the 16-bit data memory. On a start pulse it fetches a block of consecutive words and streams them to a core over a valid/ready interface. The block sits between the data memory port and a matrix-multiply core, for example to load operand rows from address 100 onward or parameters from 998/999. An internal FIFO absorbs core backpressure so that memory reads stall cleanly.

## Interface
- FIFO_DEPTH, 4, stream buffer depth in words; must be a power of two, ≥2
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request pulse; ignored while busy=1
- base_addr  in  16  first word address, latched on start
- count  in  16  number of words, latched on start; 0 is legal
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at job end
- mem_read  out  1  read strobe to memory
- mem_write  out  1  tied 0
- mem_address  out  16  read address
- mem_data_in  in  16  memory read data, combinational from mem_address in the same cycle
- out_valid  out  1  stream data valid
- out_data  out  16  stream word (FIFO head)
- out_ready  in  1  core accepts the word
- out_last  out  1  marks the final word of a job

## Operation
- Reset values: busy=0, done=0, mem_read=0, mem_write=0, mem_address=0, out_valid=0, out_data=0, out_last=0; FIFO empty; state IDLE.
- States:
  - IDLE: start → latch base/count. If count=0 → DONE, else → FETCH.
  - FETCH: mem_read=1 whenever remaining>0 and FIFO not full. At each posedge with mem_read=1, push mem_data_in, increment mem_address, decrement remaining. When remaining reaches 0 → DRAIN.
  - DRAIN: wait until the FIFO is empty and the last word has been popped → DONE.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- Address wraps 16'hFFFF → 16'h0000 with no error.
- FIFO behaviour:
  - Pop on out_valid && out_ready.
  - Push is permitted only if the FIFO is not full at the start of the cycle; a same-cycle pop gives no credit.
  - Simultaneous push and pop when not full leaves occupancy unchanged.
- out_data holds while out_valid=1 && out_ready=0.
- start during busy is dropped; the latched job is unaffected.
- rst_n low at any point aborts the job immediately; all outputs return to reset values and no done is generated.

## Timing
- Start accepted at posedge P0 → busy=1 and mem_read=1 in cycle 1. The first word is sampled at P1 and out_valid=1 in cycle 2.
- Latency from start to first valid is 2 cycles.
- Throughput is 1 word/cycle with out_ready held high.
- The last pop at posedge Pk → done=1 in cycle k+1; busy falls in that same cycle.
- count=0: done=1 in the cycle after start; no mem_read pulses.
- out_ready low: mem_read deasserts the cycle after the FIFO reaches FIFO_DEPTH. It resumes the cycle after the first pop.

## Configuration
- MEM_BURST_READER_LAST_EN defined: out_last=1 together with out_valid on the word whose index is count-1. A one-word job has out_last on its only word.
- Not defined: out_last is tied to 0 and the tracking counter is not synthesized. All other behaviour is identical.

## Test plan
- Memory[0..5]=4,4,7,5,7,2; start base=0, count=6, ready=1 → out_data 4,4,7,5,7,2 in cycles 2–7. out_last in cycle 7 (macro on), done in cycle 8.
- base=100, count=15, ready=0 for 10 cycles, then 1:
  - mem_address stops at 104 with 4 words buffered.
  - Stream is then 1,8,8,1,3,0,5,5,6,9,4,7,4,4,8 in order, with no loss or duplication.
- count=0 → done pulse the cycle after start, mem_read never asserted, out_valid never asserted.
- base=16'hFFFE, count=4 → addresses FFFE, FFFF, 0000, 0001 issued in order.
- Second start mid-job (base=998, count=2) → ignored; original job completes with a single done.
- rst_n low for 1 cycle mid-FETCH with 3 words buffered → outputs go to reset values asynchronously, FIFO empty, no done. A new start afterward behaves as from power-up.
